// File: rtl/music_box_pkg.sv
// ---------------------------------------------------------------------------
// music_box_pkg
// Shared constants and width helpers for the MusicBox key front end.
//   MB_STATE_W              width of the MusicBox state bus
//   MB_STATE_IDLE           idle state code
//   MB_STATE_PLAY_RECORDING play-recording state code
//   key_idx_w(n)            bits needed for a key index 0..n-1 (min 1)
//   key_cnt_w(n)            bits needed for a key count 0..n (min 1)
// ---------------------------------------------------------------------------
package music_box_pkg;

    localparam int MB_STATE_W = 5;

    localparam logic [MB_STATE_W-1:0] MB_STATE_IDLE           = 5'd0;
    localparam logic [MB_STATE_W-1:0] MB_STATE_PLAY_RECORDING = 5'd4;

    function automatic int key_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int key_cnt_w(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/music_key_channel.sv
// ---------------------------------------------------------------------------
// music_key_channel
// One key: two-flop synchroniser, debounce counter and stable pressed bit,
// plus an optional long-press detector (macro MUSIC_KEYS_HOLD_DETECT_EN).
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   key_raw_n      raw key pin, 0 = pressed, asynchronous
//   pressed_next   gated pressed level the top will register this edge
//   pressed_now    gated pressed level currently registered in the top
//   stable_pressed debounced (ungated) pressed bit
//   key_held       long-press flag (constant 0 without the macro)
// ---------------------------------------------------------------------------
module music_key_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    input  logic pressed_next,
    input  logic pressed_now,
    output logic stable_pressed,
    output logic key_held
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync_q;
    logic [DB_W-1:0] db_count;
    logic            synced_pressed;

    assign synced_pressed = ~sync_q;

    // Synchroniser flops rest at 1 so a reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= key_raw_n;
            sync_q    <= sync_meta;
        end
    end

    // The counter only runs while the synced input disagrees with the stable
    // bit; DEBOUNCE_CYCLES consecutive disagreeing cycles flip the stable bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_pressed <= 1'b0;
            db_count       <= '0;
        end else if (synced_pressed == stable_pressed) begin
            db_count <= '0;
        end else if (db_count == DB_LAST) begin
            stable_pressed <= synced_pressed;
            db_count       <= '0;
        end else begin
            db_count <= db_count + 1'b1;
        end
    end

`ifdef MUSIC_KEYS_HOLD_DETECT_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_count;

    // Counting starts the edge after the output went high, so the flag rises
    // HOLD_CYCLES edges after it; clearing uses the next level so the flag
    // drops on the very edge the output falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_count <= '0;
            key_held   <= 1'b0;
        end else if (!pressed_next) begin
            hold_count <= '0;
            key_held   <= 1'b0;
        end else if (pressed_now && !key_held) begin
            if (hold_count == HOLD_LAST) begin
                key_held <= 1'b1;
            end else begin
                hold_count <= hold_count + 1'b1;
            end
        end
    end
`else
    logic unused_hold_inputs;

    assign unused_hold_inputs = pressed_next ^ pressed_now ^ HOLD_CYCLES[0];
    assign key_held           = 1'b0;
`endif

endmodule

// File: rtl/music_keys_debouncer.sv
// ---------------------------------------------------------------------------
// music_keys_debouncer
// Debounced, state-gated music key front end for the frequency generator and
// recorder. Optional long-press detection: define MUSIC_KEYS_HOLD_DETECT_EN.
//   clock_50Mhz      system clock
//   reset_n          asynchronous active-low reset
//   currentState     MusicBox state (selects ENABLE_STATE_MASK bit)
//   input_MusicKey   raw keys, 0 = pressed
//   outputKeyPressed gated debounced level, 1 = pressed
//   keyPressEvent    one-cycle pulse on 0->1 of outputKeyPressed
//   keyReleaseEvent  one-cycle pulse on 1->0 of outputKeyPressed
//   activeKeyIndex   lowest pressed index (0 when none)
//   activeKeyValid   any key pressed
//   numKeysPressed   popcount of outputKeyPressed
//   keyHeld          long-press flags
//   debugString      {press-event cycle count, 3'b0, state, ungated keys}
// ---------------------------------------------------------------------------
module music_keys_debouncer
    import music_box_pkg::*;
#(
    parameter int          NUM_KEYS          = 6,
    parameter int          DEBOUNCE_CYCLES   = 500000,
    parameter logic [31:0] ENABLE_STATE_MASK = (32'd1 << MB_STATE_IDLE) |
                                               (32'd1 << MB_STATE_PLAY_RECORDING),
    parameter int          HOLD_CYCLES       = 50000000
) (
    input  logic                                clock_50Mhz,
    input  logic                                reset_n,
    input  logic [MB_STATE_W-1:0]               currentState,
    input  logic [NUM_KEYS-1:0]                 input_MusicKey,
    output logic [NUM_KEYS-1:0]                 outputKeyPressed,
    output logic [NUM_KEYS-1:0]                 keyPressEvent,
    output logic [NUM_KEYS-1:0]                 keyReleaseEvent,
    output logic [key_idx_w(NUM_KEYS)-1:0]      activeKeyIndex,
    output logic                                activeKeyValid,
    output logic [key_cnt_w(NUM_KEYS)-1:0]      numKeysPressed,
    output logic [NUM_KEYS-1:0]                 keyHeld,
    output logic [31:0]                         debugString
);

    localparam int KEY_IDX_W = key_idx_w(NUM_KEYS);
    localparam int KEY_CNT_W = key_cnt_w(NUM_KEYS);

    logic [NUM_KEYS-1:0]   stable_vec;
    logic [NUM_KEYS-1:0]   out_next;
    logic [NUM_KEYS-1:0]   press_next;
    logic [NUM_KEYS-1:0]   release_next;
    logic                  enabled;
    logic [KEY_IDX_W-1:0]  idx_next;
    logic [KEY_CNT_W-1:0]  cnt_next;
    logic [15:0]           stable_dbg;
    logic [MB_STATE_W-1:0] state_dbg;
    logic [7:0]            press_count;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        music_key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_channel (
            .clk            (clock_50Mhz),
            .rst_n          (reset_n),
            .key_raw_n      (input_MusicKey[i]),
            .pressed_next   (out_next[i]),
            .pressed_now    (outputKeyPressed[i]),
            .stable_pressed (stable_vec[i]),
            .key_held       (keyHeld[i])
        );
    end

    assign enabled      = ENABLE_STATE_MASK[currentState];
    assign out_next     = stable_vec & {NUM_KEYS{enabled}};
    assign press_next   = out_next & ~outputKeyPressed;
    assign release_next = ~out_next & outputKeyPressed;

    // Summary values are taken from the next output level so they line up
    // with outputKeyPressed after the register.
    always_comb begin
        idx_next = '0;
        cnt_next = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (out_next[i]) idx_next = KEY_IDX_W'(i);
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_next = cnt_next + KEY_CNT_W'(out_next[i]);
        end
    end

    // Output register; reset clears the level without raising release events.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            outputKeyPressed <= '0;
            keyPressEvent    <= '0;
            keyReleaseEvent  <= '0;
            activeKeyIndex   <= '0;
            activeKeyValid   <= 1'b0;
            numKeysPressed   <= '0;
        end else begin
            outputKeyPressed <= out_next;
            keyPressEvent    <= press_next;
            keyReleaseEvent  <= release_next;
            activeKeyIndex   <= idx_next;
            activeKeyValid   <= |out_next;
            numKeysPressed   <= cnt_next;
        end
    end

    // Debug word is fully registered so it reads 0 during reset.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            stable_dbg  <= '0;
            state_dbg   <= '0;
            press_count <= '0;
        end else begin
            stable_dbg  <= 16'(stable_vec);
            state_dbg   <= currentState;
            press_count <= press_count + 8'(|press_next);
        end
    end

    assign debugString = {press_count, 3'b000, state_dbg, stable_dbg};

endmodule

// File: doc/music_keys_debouncer.md
# music_keys_debouncer

Parametrised replacement for the music-key front end. Synchronises and debounces NUM_KEYS active-low key inputs, gates them by the MusicBox state, and produces registered level, press/release pulse, lowest-key priority and key-count outputs for the frequency generator and recorder. Sits between the board key pins and the frequency generator; `currentState` comes from MusicBoxStateController.

## Interface
- NUM_KEYS, 6: number of keys; legal range 1..16.
- DEBOUNCE_CYCLES, 500000: cycles a synchronised input must differ from the debounced state before it is accepted (10 ms at 50 MHz); must be at least 1.
- ENABLE_STATE_MASK, 32'h0000_0011: bit s set means keys are live in state s. Default enables states 0 (idle) and 4 (play recording).
- HOLD_CYCLES, 50000000: continuous gated-press length for a hold (1 s); used only with the hold feature.
- clock_50Mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- currentState  in  5  MusicBox state.
- input_MusicKey  in  NUM_KEYS  raw keys, 0 = pressed, asynchronous to the clock.
- outputKeyPressed  out  NUM_KEYS  gated debounced level, 1 = pressed.
- keyPressEvent  out  NUM_KEYS  one-cycle pulse on a 0→1 transition of outputKeyPressed.
- keyReleaseEvent  out  NUM_KEYS  one-cycle pulse on a 1→0 transition of outputKeyPressed.
- activeKeyIndex  out  KEY_IDX_W  lowest index with outputKeyPressed set; 0 when none.
- activeKeyValid  out  1  high when any outputKeyPressed bit is set.
- numKeysPressed  out  KEY_CNT_W  popcount of outputKeyPressed.
- keyHeld  out  NUM_KEYS  long-press flag.
- debugString  out  32  [15:0] ungated debounced pressed vector, zero-extended; [20:16] currentState; [23:21] 0; [31:24] wrapping count of keyPressEvent cycles.

## Operation
- Synchronisation: two flops per key. They reset to 1 (released).
- Debounce, per key: stable pressed bit plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synced value equal to stable: the counter clears.
  - Synced value differs: the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable flips and the counter clears.
  - Any bounce back resets the count. Glitches shorter than DEBOUNCE_CYCLES cycles are never seen.
- Gating: enabled = ENABLE_STATE_MASK[currentState]. The next outputKeyPressed is stable & {NUM_KEYS{enabled}}.
- Events are derived from the registered outputKeyPressed against its previous value.
  - Leaving an enabled state while keys are held gives a release event for each held key, so no note sticks.
  - Entering an enabled state while keys are held gives press events.
- activeKeyIndex, activeKeyValid and numKeysPressed are registered and computed from the next value of outputKeyPressed, so they change in the same cycle as outputKeyPressed.
- Simultaneous presses on several keys produce several event bits in the same cycle. numKeysPressed saturates naturally at NUM_KEYS.

## Timing
- Reset (asynchronous, immediate):
  - All outputs 0.
  - Synchronisers 1, stable bits released, counters 0.
  - No release events are generated by reset.
- Latency from a clean raw press edge to outputKeyPressed: 2 (sync) + DEBOUNCE_CYCLES + 1 (output register) rising edges. The event pulse is in that same cycle. Release latency is identical.
- A change in currentState affects outputKeyPressed after 1 edge. It does not restart debounce.
- keyPressEvent and keyReleaseEvent for one key are never high in the same cycle.

## Configuration
- MUSIC_KEYS_HOLD_DETECT_EN defined:
  - Per-key hold counter, width $clog2(HOLD_CYCLES+1), cleared while outputKeyPressed[i] is 0.
  - keyHeld[i] rises on the edge where the counter reaches HOLD_CYCLES-1.
  - keyHeld[i] stays high until outputKeyPressed[i] falls, and clears in that same cycle.
- Undefined: keyHeld is constant 0 and no hold counters are built.

## Structure
- Package music_box_pkg holds:
  - state constants MB_STATE_IDLE = 5'd0 and MB_STATE_PLAY_RECORDING = 5'd4;
  - MB_STATE_W = 5;
  - functions key_idx_w(n) and key_cnt_w(n), returning $clog2 widths with a minimum of 1.
- Sub-module music_key_channel: one instance per key (generate loop), containing the synchroniser, debounce counter, stable bit and optional hold counter.
- Gating, edge detection, priority encoding, popcount and debugString live in the top level.

## Test plan
The bench uses NUM_KEYS=6, DEBOUNCE_CYCLES=4 and HOLD_CYCLES=20.
- Clean press: hold key 2 low in state 0. Required:
  - outputKeyPressed = 6'b000100 on edge 7;
  - keyPressEvent[2] high for exactly that cycle;
  - activeKeyIndex = 2, numKeysPressed = 1.
- Bounce: toggle key 1 every 2 cycles for 20 cycles, then release. Required: no output or event activity.
- Gating: press keys 0 and 5 in state 0, then set currentState = 2. Required:
  - one edge later, outputKeyPressed = 0 and keyReleaseEvent = 6'b100001;
  - returning to state 4 gives keyPressEvent = 6'b100001.
- Priority and count: press keys 3, 1 and 4 together. Required: activeKeyIndex = 1 and numKeysPressed = 3 in the same cycle as the outputs.
- Reset mid-press: with key 0 pressed, pulse reset_n low. Required:
  - all outputs 0 immediately, with no release event;
  - key 0 still held after reset reappears after 7 edges.
- Hold, with MUSIC_KEYS_HOLD_DETECT_EN: keep key 3 pressed. Required:
  - keyHeld[3] rises 20 edges after outputKeyPressed[3];
  - keyHeld[3] clears with the release.
  - Without the macro, keyHeld stays 0.
